// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Glyphs are active-high {g,f,e,d,c,b,a}. Output polarity is applied later,
// at the display_scan output register.
package display_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_A     = 7'h77;
  localparam seg_t SEG_B     = 7'h7C;  // lower-case b
  localparam seg_t SEG_C     = 7'h39;
  localparam seg_t SEG_D     = 7'h5E;  // lower-case d
  localparam seg_t SEG_E     = 7'h79;
  localparam seg_t SEG_F     = 7'h71;
  localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// Nibble to seven-segment glyph decoder (hex 0-9, A, b, C, d, E, F).
// Latency: purely combinational. Backpressure: none.
// Ports: nibble (4-bit value in), seg (active-high seg_t out, {g,f,e,d,c,b,a}).
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed 4-digit seven-segment driver, one digit per rising edge of
// the sampled clk_display level; double-buffered value swapped at frame start.
// Latency: outputs registered, 1 clk after the clk_display edge is sampled.
// Backpressure: data_ready = shadow empty; a held data_valid waits for the
// next frame swap to free the shadow buffer.
// Ports: clk, rst (async, active-high), clk_display (sampled level),
//   data_in/dp_in/data_valid/data_ready (value handshake),
//   an/seg/dp (display lines, polarity set by ACTIVE_LOW).
// Optional: define DISPLAY_SCAN_LZB_EN for leading-zero blanking of digits 3..1.
module display_scan
  import display_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_display,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  logic        prev;
  logic        step;
  logic        running;
  logic        pending;
  logic [1:0]  idx;
  logic [19:0] active;   // {value[15:0], dp[3:0]}
  logic [19:0] shadow;
  logic        swap;
  logic        xfer;

  assign step       = clk_display & ~prev;
  // Frame boundary: the step that wraps 3 -> 0, or the very first step.
  assign swap       = step & (~running | (idx == 2'd3));
  assign data_ready = ~pending;
  assign xfer       = data_valid & ~pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev    <= 1'b0;
      running <= 1'b0;
      idx     <= 2'd0;
      active  <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      prev <= clk_display;
      if (step) begin
        running <= 1'b1;
        if (running) idx <= idx + 2'd1;
      end
      // A transfer cannot coincide with a pending swap since ready is low.
      if (swap && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end else if (xfer) begin
        shadow  <= {data_in, dp_in};
        pending <= 1'b1;
      end
    end
  end

  logic [15:0] act_data;
  logic [3:0]  act_dp;
  logic [3:0]  cur_nib;
  logic        cur_dp;
  seg_t        glyph;
  seg_t        seg_on;
  logic        blank;
  logic [NUM_DIGITS-1:0] onehot;

  assign act_data = active[19:4];
  assign act_dp   = active[3:0];
  assign cur_nib  = act_data[{idx, 2'b00} +: 4];
  assign cur_dp   = act_dp[idx];
  assign onehot   = 4'b0001 << idx;

  seg7_decode u_dec (
    .nibble (cur_nib),
    .seg    (glyph)
  );

`ifdef DISPLAY_SCAN_LZB_EN
  // Blank a digit when it and every higher digit are zero; digit 0 always shows.
  always_comb begin
    blank = 1'b0;
    case (idx)
      2'd3:    blank = (act_data[15:12] == 4'h0);
      2'd2:    blank = (act_data[15:8]  == 8'h00);
      2'd1:    blank = (act_data[15:4]  == 12'h000);
      default: blank = 1'b0;
    endcase
  end
`else
  always_comb begin
    blank = 1'b0;
  end
`endif

  assign seg_on = blank ? SEG_BLANK : glyph;

  // Outputs stay dark until the first step; polarity applied here only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= {4{ACTIVE_LOW}};
      seg <= {7{ACTIVE_LOW}};
      dp  <= ACTIVE_LOW;
    end else if (!running) begin
      an  <= {4{ACTIVE_LOW}};
      seg <= {7{ACTIVE_LOW}};
      dp  <= ACTIVE_LOW;
    end else begin
      an  <= ACTIVE_LOW ? ~onehot : onehot;
      seg <= ACTIVE_LOW ? ~seg_on : seg_on;
      dp  <= cur_dp ^ ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
module tb_display_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_display = 1'b0;
  logic [15:0] data_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  display_scan #(.ACTIVE_LOW(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_display (clk_display),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .an          (an),
    .seg         (seg),
    .dp          (dp)
  );

  always #5 clk = ~clk;

  // Lit segments of each hex glyph, {g,f,e,d,c,b,a}.
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

`ifdef DISPLAY_SCAN_LZB_EN
  localparam logic [6:0] HI_ZERO = 7'b1111111;
`else
  localparam logic [6:0] HI_ZERO = 7'b1000000;
`endif

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Producer drive values, held until the model sees them accepted.
  logic        drv_valid = 1'b0;
  logic [15:0] drv_data  = 16'h0;
  logic [3:0]  drv_dp    = 4'h0;

  // Behavioural model: shown value, one-deep pending slot, digit position.
  int          m_val, m_dpv, m_sh_val, m_sh_dp, m_digit;
  bit          m_pending, m_running, m_prev;
  logic [11:0] m_out;

  function automatic logic [11:0] view();
    logic [3:0] a;
    logic [6:0] s;
    logic       d;
    int         nib;
    if (!m_running) return 12'hFFF;
    nib = (m_val >> (4 * m_digit)) & 15;
    s = GLYPH[nib];
`ifdef DISPLAY_SCAN_LZB_EN
    if (m_digit > 0 && (m_val >> (4 * m_digit)) == 0) s = 7'h00;
`endif
    a = 4'(1 << m_digit);
    d = 1'((m_dpv >> m_digit) & 1);
    return {~a, ~s, ~d};
  endfunction

  // One clock cycle: drive at a negedge, advance the model, check at next negedge.
  task automatic cyc(input logic disp);
    bit          stp;
    bit          acc;
    logic [11:0] nxt;
    clk_display = disp;
    data_valid  = drv_valid;
    data_in     = drv_data;
    dp_in       = drv_dp;
    stp = disp && !m_prev;
    acc = drv_valid && !m_pending;
    nxt = view();
    m_prev = disp;
    if (stp) begin
      if ((!m_running || m_digit == 3) && m_pending) begin
        m_val = m_sh_val;
        m_dpv = m_sh_dp;
        m_pending = 0;
      end
      if (m_running) m_digit = (m_digit + 1) % 4;
      m_running = 1;
    end
    if (acc) begin
      m_sh_val = drv_data;
      m_sh_dp = drv_dp;
      m_pending = 1;
    end
    m_out = nxt;
    @(negedge clk);
    check("model", {an, seg, dp, data_ready}, {m_out, !m_pending});
    if (acc) drv_valid = 1'b0;
  endtask

  task automatic disp_edge();
    cyc(1'b1);
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b0);
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] d);
    drv_valid = 1'b1;
    drv_data  = v;
    drv_dp    = d;
    cyc(1'b0);
  endtask

  // Called at a negedge; checks the asynchronous clear before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("reset_async", {an, seg, dp, data_ready}, 13'h1FFF);
    m_val = 0; m_dpv = 0; m_sh_val = 0; m_sh_dp = 0; m_digit = 0;
    m_pending = 0; m_running = 0; m_prev = 0;
    m_out = 12'hFFF;
    drv_valid = 1'b0;
    clk_display = 1'b0;
    data_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit         ld;
    logic [15:0] val;
    logic [3:0]  dpv;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  vec_t tab [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Digit 0 is the low nibble, so 16'h1234 scans 4,3,2,1.
    tab[0] = '{1'b1, 16'h1234, 4'b0001, 4'b1111, 7'b1111111, 1'b1};
    tab[1] = '{1'b0, 16'h0,    4'h0,    4'b1110, 7'b0011001, 1'b0};
    tab[2] = '{1'b0, 16'h0,    4'h0,    4'b1101, 7'b0110000, 1'b1};
    tab[3] = '{1'b0, 16'h0,    4'h0,    4'b1011, 7'b0100100, 1'b1};
    tab[4] = '{1'b0, 16'h0,    4'h0,    4'b0111, 7'b1111001, 1'b1};

    @(negedge clk);
    do_reset();

    // Idle after reset: everything dark, ready high.
    repeat (100) cyc(1'b0);
    check("reset_hold", {an, seg, dp, data_ready}, 13'h1FFF);

    // Load then four digit steps.
    for (int i = 0; i < 5; i++) begin
      if (tab[i].ld) begin
        load(tab[i].val, tab[i].dpv);
        check("tab_ready", {31'h0, data_ready}, 32'h0);
      end else begin
        disp_edge();
      end
      check("tab_an",  {28'h0, an},  {28'h0, tab[i].an});
      check("tab_seg", {25'h0, seg}, {25'h0, tab[i].seg});
      check("tab_dp",  {31'h0, dp},  {31'h0, tab[i].dp});
    end

    // Mid-frame update: new value waits for the next frame start.
    disp_edge();
    disp_edge();
    load(16'hAAAA, 4'h0);
    check("mid_ready_low", {31'h0, data_ready}, 32'h0);
    disp_edge();
    check("mid_old_d2", {25'h0, seg}, {25'h0, 7'b0100100});
    disp_edge();
    check("mid_old_d3", {25'h0, seg}, {25'h0, 7'b1111001});
    cyc(1'b1);
    check("mid_ready_back", {31'h0, data_ready}, 32'h1);
    cyc(1'b1);
    check("mid_new_d0", {an, seg}, {4'b1110, 7'b0001000});
    cyc(1'b0);
    cyc(1'b0);

    // Back-pressure: second offer held while the slot is full.
    load(16'h5678, 4'b1000);
    drv_valid = 1'b1;
    drv_data  = 16'h9ABC;
    drv_dp    = 4'h0;
    repeat (3) cyc(1'b0);
    check("bp_ready_low", {31'h0, data_ready}, 32'h0);
    disp_edge();
    disp_edge();
    disp_edge();
    check("bp_old_d3", {an, seg}, {4'b0111, 7'b0001000});
    disp_edge();
    check("bp_first_d0", {an, seg, dp}, {4'b1110, 7'b0000000, 1'b1});
    check("bp_second_taken", {31'h0, data_ready}, 32'h0);
    disp_edge();
    disp_edge();
    disp_edge();
    check("bp_first_d3", {an, seg, dp}, {4'b0111, 7'b0010010, 1'b0});
    disp_edge();
    check("bp_second_d0", {an, seg}, {4'b1110, 7'b1000110});

    // Reset at digit 2 with a value pending: it must never appear.
    disp_edge();
    disp_edge();
    load(16'hFFFF, 4'hF);
    do_reset();
    disp_edge();
    check("rst_discard", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
    repeat (4) disp_edge();

    // Leading zeros of 16'h0070.
    load(16'h0070, 4'h0);
    repeat (4) disp_edge();
    check("lz_d0", {an, seg}, {4'b1110, 7'b1000000});
    disp_edge();
    check("lz_d1", {an, seg}, {4'b1101, 7'b1111000});
    disp_edge();
    check("lz_d2", {an, seg}, {4'b1011, HI_ZERO});
    disp_edge();
    check("lz_d3", {an, seg}, {4'b0111, HI_ZERO});

    // Random traffic against the model.
    drv_valid = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      int   r;
      logic lvl;
      r = $urandom_range(0, 9);
      if (!drv_valid && r < 2) begin
        drv_valid = 1'b1;
        drv_data  = 16'($urandom);
        drv_dp    = 4'($urandom);
      end else if (drv_valid && r == 9) begin
        drv_valid = 1'b0;
      end
      if ($urandom_range(0, 599) == 0) do_reset();
      lvl = clk_display;
      if ($urandom_range(0, 3) == 0) lvl = ~lvl;
      cyc(lvl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
